incremental_conversion_sequencer: RTL and testbench

- Sequences one incremental-ADC conversion at a time around the 16-bit CIC decimation filter running in type 1 (incremental) mode.
- Holds the modulator in reset, clears the filter, and counts OSR samples.
- At the end of the count it pulses the filter reset so the filter dumps its result, then captures that result.
- Presents the result on a valid/ready interface to downstream logic, in single-shot or continuous mode.

---
 rtl/decimation_ctrl_pkg.sv | 18 +
 rtl/incremental_conversion_sequencer_if.sv | 30 +++
 rtl/conv_result_buffer.sv | 44 ++++
 rtl/incremental_conversion_sequencer.sv | 131 +++++++++++++
 tb/tb_incremental_conversion_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/decimation_ctrl_pkg.sv
// Shared types and constants for the incremental-ADC conversion sequencer.
package decimation_ctrl_pkg;

  localparam int unsigned DATA_BITS_DEFAULT = 16;
  localparam int unsigned OSR_WIDTH_DEFAULT = 8;

  // Filter type_dec value that selects incremental (type 1) operation
  localparam logic TYPE_INCREMENTAL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_INTEGRATE,
    ST_DUMP,
    ST_CAPTURE
  } seq_state_e;

endpackage

// File: rtl/incremental_conversion_sequencer_if.sv
// Result valid/ready handshake plus sticky overrun status towards the consumer.
interface incremental_conversion_sequencer_if
  import decimation_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT
);

  logic [DATA_BITS-1:0] result;
  logic                 result_valid;
  logic                 result_ready;
  logic                 overrun;
  logic                 clear_overrun;

  modport master (
    output result,
    output result_valid,
    output overrun,
    input  result_ready,
    input  clear_overrun
  );

  modport slave (
    input  result,
    input  result_valid,
    input  overrun,
    output result_ready,
    output clear_overrun
  );

endinterface

// File: rtl/conv_result_buffer.sv
// Holds the latest conversion result with valid/ready handshake and sticky overrun.
module conv_result_buffer
  import decimation_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture_c,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 result_ready,
  input  logic                 clear_overrun,
  output logic [DATA_BITS-1:0] result,
  output logic                 result_valid,
  output logic                 overrun
);

  // Overwriting a result that is neither read before nor during this cycle
  logic overrun_set_c;
  assign overrun_set_c = capture_c && result_valid && !result_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (capture_c) begin
        result       <= din;
        result_valid <= 1'b1;
      end else if (result_ready) begin
        result_valid <= 1'b0;
      end

      // Set has priority over clear
      if (overrun_set_c) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/incremental_conversion_sequencer.sv
// Sequences incremental-mode CIC conversions: modulator reset, filter clear,
// OSR sample count, filter dump and result capture.
module incremental_conversion_sequencer
  import decimation_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITS      = DATA_BITS_DEFAULT,
  parameter int unsigned OSR_WIDTH      = OSR_WIDTH_DEFAULT,
  parameter int unsigned MOD_RST_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  input  logic [OSR_WIDTH-1:0] osr,
  output logic                 mod_rst,
  output logic                 filt_reset,
  output logic                 filt_type_dec,
  input  logic [DATA_BITS-1:0] filt_z,
  output logic                 busy,
  incremental_conversion_sequencer_if.master res_if
);

  localparam int unsigned      CLR_W       = (MOD_RST_CYCLES > 1) ? $clog2(MOD_RST_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LOAD    = CLR_W'(MOD_RST_CYCLES - 1);
  localparam logic             CLEAR_PULSE = (MOD_RST_CYCLES == 1);

  seq_state_e           state;
  logic [CLR_W-1:0]     clr_cnt;
  logic [OSR_WIDTH-1:0] smp_cnt;
  logic [OSR_WIDTH-1:0] osr_q;
  logic [OSR_WIDTH-1:0] osr_eff_c;
  logic                 capture_c;

  assign osr_eff_c     = (osr == '0) ? OSR_WIDTH'(1) : osr;
  assign filt_type_dec = TYPE_INCREMENTAL;
  assign capture_c     = (state == ST_CAPTURE) && !abort;

  // Outputs are registered from the state being entered, so filt_reset is
  // high exactly during the last CLEAR cycle and the single DUMP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      mod_rst    <= 1'b1;
      filt_reset <= 1'b0;
      busy       <= 1'b0;
      clr_cnt    <= '0;
      smp_cnt    <= '0;
      osr_q      <= '0;
    end else if (abort) begin
      state      <= ST_IDLE;
      mod_rst    <= 1'b1;
      filt_reset <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start || continuous) begin
            state      <= ST_CLEAR;
            busy       <= 1'b1;
            osr_q      <= osr_eff_c;
            clr_cnt    <= CLR_LOAD;
            filt_reset <= CLEAR_PULSE;
          end
          mod_rst <= 1'b1;
        end

        ST_CLEAR: begin
          if (clr_cnt == '0) begin
            state      <= ST_INTEGRATE;
            smp_cnt    <= osr_q - OSR_WIDTH'(1);
            mod_rst    <= 1'b0;
            filt_reset <= 1'b0;
          end else begin
            clr_cnt    <= clr_cnt - CLR_W'(1);
            filt_reset <= (clr_cnt == CLR_W'(1));
          end
        end

        ST_INTEGRATE: begin
          if (smp_cnt == '0) begin
            state      <= ST_DUMP;
            filt_reset <= 1'b1;
            mod_rst    <= 1'b1;
          end else begin
            smp_cnt <= smp_cnt - OSR_WIDTH'(1);
          end
        end

        ST_DUMP: begin
          state      <= ST_CAPTURE;
          filt_reset <= 1'b0;
        end

        ST_CAPTURE: begin
          if (continuous) begin
            state      <= ST_CLEAR;
            clr_cnt    <= CLR_LOAD;
            filt_reset <= CLEAR_PULSE;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          mod_rst <= 1'b1;
        end

        default: begin
          state      <= ST_IDLE;
          mod_rst    <= 1'b1;
          filt_reset <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  conv_result_buffer #(
    .DATA_BITS (DATA_BITS)
  ) u_result_buffer (
    .clk           (clk),
    .reset         (reset),
    .capture_c     (capture_c),
    .din           (filt_z),
    .result_ready  (res_if.result_ready),
    .clear_overrun (res_if.clear_overrun),
    .result        (res_if.result),
    .result_valid  (res_if.result_valid),
    .overrun       (res_if.overrun)
  );

endmodule

// File: tb/tb_incremental_conversion_sequencer.sv
// Bench for the conversion sequencer driving a behavioural incremental CIC filter.
module tb_incremental_conversion_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        continuous;
  logic        abort;
  logic [7:0]  osr;
  logic        mod_rst;
  logic        filt_reset;
  logic        filt_type_dec;
  logic [15:0] filt_z;
  logic        busy;
  logic        x_in;

  int tests = 0;
  int fails = 0;

  incremental_conversion_sequencer_if #(.DATA_BITS(16)) res_if ();

  incremental_conversion_sequencer #(
    .DATA_BITS      (16),
    .OSR_WIDTH      (8),
    .MOD_RST_CYCLES (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .continuous    (continuous),
    .abort         (abort),
    .osr           (osr),
    .mod_rst       (mod_rst),
    .filt_reset    (filt_reset),
    .filt_type_dec (filt_type_dec),
    .filt_z        (filt_z),
    .busy          (busy),
    .res_if        (res_if)
  );

  // Incremental CIC model: Y sums the running sum; reset edge dumps Z<=Y and clears
  logic [15:0] f_s1, f_y;
  logic        x_mod;
  assign x_mod = mod_rst ? 1'b0 : x_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_s1   <= '0;
      f_y    <= '0;
      filt_z <= '0;
    end else if (filt_reset) begin
      f_s1   <= '0;
      f_y    <= '0;
      filt_z <= f_y;
    end else begin
      f_s1 <= f_s1 + 16'(x_mod);
      f_y  <= f_y + f_s1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       x;
    logic [7:0] osr;
    int         exp_result;
    int         exp_latency;
  } vec_t;

  // One single-shot conversion with result_ready=1; checks latency, result, pulses
  task automatic run_conv(input logic xv, input logic [7:0] ov, input int exp_res,
                          input int exp_lat, input string tag);
    int edges;
    int pulses;
    bit prev_fr;
    bit double_fr;
    bit seen;
    @(negedge clk);
    x_in  = xv;
    osr   = ov;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    edges     = 0;
    pulses    = 0;
    prev_fr   = 1'b0;
    double_fr = 1'b0;
    seen      = 1'b0;
    while (edges < exp_lat + 20 && !seen) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (filt_reset) begin
        pulses++;
        if (prev_fr) double_fr = 1'b1;
      end
      prev_fr = filt_reset;
      if (res_if.result_valid) seen = 1'b1;
    end
    check({tag, " valid_seen"}, int'(seen), 1);
    check({tag, " latency"}, edges, exp_lat);
    check({tag, " result"}, int'(res_if.result), exp_res);
    check({tag, " filt_reset_pulses"}, pulses, 2);
    check({tag, " filt_reset_back_to_back"}, int'(double_fr), 0);
    check({tag, " busy_done"}, int'(busy), 0);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    bit ok;
    bit flag;
    logic [15:0] r_before;

    vecs[0] = '{x: 1'b1, osr: 8'd16,  exp_result: 120,   exp_latency: 20};
    vecs[1] = '{x: 1'b0, osr: 8'd4,   exp_result: 0,     exp_latency: 8};
    vecs[2] = '{x: 1'b1, osr: 8'd4,   exp_result: 6,     exp_latency: 8};
    vecs[3] = '{x: 1'b1, osr: 8'd0,   exp_result: 0,     exp_latency: 5};
    vecs[4] = '{x: 1'b1, osr: 8'd1,   exp_result: 0,     exp_latency: 5};
    vecs[5] = '{x: 1'b1, osr: 8'd255, exp_result: 32385, exp_latency: 259};

    reset                = 1'b1;
    start                = 1'b0;
    continuous           = 1'b0;
    abort                = 1'b0;
    osr                  = 8'd0;
    x_in                 = 1'b0;
    res_if.result_ready  = 1'b1;
    res_if.clear_overrun = 1'b0;

    repeat (3) @(negedge clk);
    check("rst busy", int'(busy), 0);
    check("rst mod_rst", int'(mod_rst), 1);
    check("rst filt_reset", int'(filt_reset), 0);
    check("rst result_valid", int'(res_if.result_valid), 0);
    check("rst result", int'(res_if.result), 0);
    check("rst overrun", int'(res_if.overrun), 0);
    check("filt_type_dec", int'(filt_type_dec), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_conv(vecs[i].x, vecs[i].osr, vecs[i].exp_result, vecs[i].exp_latency,
               $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d valid_cleared", i), int'(res_if.result_valid), 0);
    end

    // Continuous mode with a stalled consumer
    @(negedge clk);
    x_in                = 1'b1;
    osr                 = 8'd8;
    res_if.result_ready = 1'b0;
    continuous          = 1'b1;
    n = 0;
    while (n < 40 && !res_if.result_valid) begin @(negedge clk); n++; end
    check("cont first_valid", int'(res_if.result_valid), 1);
    check("cont first_result", int'(res_if.result), 28);
    check("cont first_overrun", int'(res_if.overrun), 0);
    n = 0;
    while (n < 40 && !res_if.overrun) begin @(negedge clk); n++; end
    check("cont overrun_set", int'(res_if.overrun), 1);
    check("cont overrun_result", int'(res_if.result), 28);
    check("cont overrun_valid", int'(res_if.result_valid), 1);
    check("cont busy_mid", int'(busy), 1);
    continuous = 1'b0;
    n = 0;
    while (n < 40 && busy) begin @(negedge clk); n++; end
    check("cont drop_idle", int'(busy), 0);
    check("cont drop_result", int'(res_if.result), 28);
    res_if.clear_overrun = 1'b1;
    @(negedge clk);
    res_if.clear_overrun = 1'b0;
    check("cont clear_overrun", int'(res_if.overrun), 0);
    check("cont valid_held", int'(res_if.result_valid), 1);
    repeat (3) @(negedge clk);
    check("cont stays_idle", int'(busy), 0);
    res_if.result_ready = 1'b1;
    @(negedge clk);
    check("cont accepted", int'(res_if.result_valid), 0);

    // Abort during INTEGRATE
    r_before = res_if.result;
    x_in  = 1'b1;
    osr   = 8'd16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 10 && mod_rst) begin @(negedge clk); n++; end
    check("abort reached_integrate", int'(mod_rst), 0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort mod_rst", int'(mod_rst), 1);
    check("abort filt_reset", int'(filt_reset), 0);
    check("abort valid", int'(res_if.result_valid), 0);
    flag = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (res_if.result_valid || busy) flag = 1'b1;
    end
    check("abort no_result", int'(flag), 0);
    check("abort result_kept", int'(res_if.result), int'(r_before));
    run_conv(1'b1, 8'd16, 120, 20, "after_abort");

    // Async reset asserted mid-DUMP with a pending result
    @(negedge clk);
    res_if.result_ready = 1'b0;
    x_in  = 1'b1;
    osr   = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 20 && !res_if.result_valid) begin @(negedge clk); n++; end
    check("prereset result", int'(res_if.result), 6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n  = 0;
    ok = 1'b0;
    begin
      int pulses;
      pulses = 0;
      while (n < 20 && !ok) begin
        if (filt_reset) pulses++;
        if (pulses == 2) ok = 1'b1;
        else begin @(negedge clk); n++; end
      end
    end
    check("prereset in_dump", int'(ok && busy && mod_rst), 1);
    #2 reset = 1'b1;
    #1;
    check("async busy", int'(busy), 0);
    check("async mod_rst", int'(mod_rst), 1);
    check("async filt_reset", int'(filt_reset), 0);
    check("async valid", int'(res_if.result_valid), 0);
    check("async result", int'(res_if.result), 0);
    check("async overrun", int'(res_if.overrun), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
